// File: rtl/vfp_config_sequencer.sv
// AXI4-Lite master that replays an (address, data) table into the VFP config space.
// Define VFP_CFG_READBACK_EN to read back and compare each entry after its write.
module vfp_config_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TBL_DEPTH      = 16,
  parameter int TBL_AW         = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tbl_we,
  input  logic [TBL_AW-1:0]       tbl_idx,
  input  logic [ADDR_WIDTH-1:0]   tbl_addr,
  input  logic [DATA_WIDTH-1:0]   tbl_data,
  input  logic [TBL_AW:0]         num_entries,
  input  logic                    sync_frame,
  input  logic                    eof,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [TBL_AW-1:0]       err_idx,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EOF,
    WR_REQ,
    WR_RESP,
`ifdef VFP_CFG_READBACK_EN
    RD_REQ,
    RD_RESP,
`endif
    NEXT,
    FINISH
  } state_t;

  logic [ADDR_WIDTH-1:0] tbl_addr_mem [TBL_DEPTH];
  logic [DATA_WIDTH-1:0] tbl_data_mem [TBL_DEPTH];

  state_t                state_q, state_d;
  logic [TBL_AW-1:0]     idx_q, idx_d;
  logic [TBL_AW:0]       num_q, num_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  arvalid_q, arvalid_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  error_q, error_d;
  logic [TBL_AW-1:0]     err_idx_q, err_idx_d;

  logic                  timed;
  logic                  tmo_hit;
  logic                  fail;
  logic                  issue;
  logic [TBL_AW-1:0]     issue_idx;

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_addr_mem[tbl_idx] <= tbl_addr;
      tbl_data_mem[tbl_idx] <= tbl_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arvalid_d = arvalid_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    fail      = 1'b0;
    issue     = 1'b0;
    issue_idx = idx_q;

    timed = (state_q == WR_REQ) || (state_q == WR_RESP);
`ifdef VFP_CFG_READBACK_EN
    timed = timed || (state_q == RD_REQ) || (state_q == RD_RESP);
`endif
    tmo_hit = timed && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_entries == '0) begin
            state_d = FINISH;
          end else begin
            error_d   = 1'b0;
            err_idx_d = '0;
            num_d     = num_entries;
            if (sync_frame) begin
              state_d = WAIT_EOF;
            end else begin
              issue     = 1'b1;
              issue_idx = '0;
              state_d   = WR_REQ;
            end
          end
        end
      end
      WAIT_EOF: begin
        if (eof) begin
          issue     = 1'b1;
          issue_idx = '0;
          state_d   = WR_REQ;
        end
      end
      WR_REQ: begin
        if (tmo_hit) begin
          fail = 1'b1;
        end else begin
          if (awvalid_q && awready) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
          end
          if (wvalid_q && wready) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end
          // Both handshakes are seen from the registered flags, so simultaneous acceptance works too.
          if (aw_done_q && w_done_q) begin
            state_d = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (tmo_hit) begin
          fail = 1'b1;
        end else if (bvalid) begin
          if (bresp != 2'b00) begin
            fail = 1'b1;
          end else begin
`ifdef VFP_CFG_READBACK_EN
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
`else
            state_d   = NEXT;
`endif
          end
        end
      end
`ifdef VFP_CFG_READBACK_EN
      RD_REQ: begin
        if (tmo_hit) begin
          fail = 1'b1;
        end else if (arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (tmo_hit) begin
          fail = 1'b1;
        end else if (rvalid) begin
          if ((rresp != 2'b00) || (rdata != wdata_q)) begin
            fail = 1'b1;
          end else begin
            state_d = NEXT;
          end
        end
      end
`endif
      NEXT: begin
        if ({1'b0, idx_q} == (num_q - 1'b1)) begin
          state_d = FINISH;
        end else begin
          issue     = 1'b1;
          issue_idx = idx_q + 1'b1;
          state_d   = WR_REQ;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fail) begin
      error_d   = 1'b1;
      err_idx_d = idx_q;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      state_d   = FINISH;
    end

    // The address/data registers act as the table's registered read port.
    if (issue) begin
      idx_d     = issue_idx;
      awaddr_d  = tbl_addr_mem[issue_idx];
      wdata_d   = tbl_data_mem[issue_idx];
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end

    tmo_d = '0;
    if (timed && (state_d == state_q)) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      num_q     <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      arvalid_q <= 1'b0;
      tmo_q     <= '0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      arvalid_q <= arvalid_d;
      tmo_q     <= tmo_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign busy    = (state_q != IDLE) && (state_q != FINISH);
  assign done    = (state_q == FINISH);
  assign error   = error_q;
  assign err_idx = err_idx_q;
  assign awaddr  = awaddr_q;
  assign awprot  = 3'b000;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = '1;
  assign wvalid  = wvalid_q;
  assign bready  = (state_q == WR_RESP);
  assign araddr  = awaddr_q;
  assign arprot  = 3'b000;

`ifdef VFP_CFG_READBACK_EN
  assign arvalid = arvalid_q;
  assign rready  = (state_q == RD_RESP);
`else
  logic unused_rd;
  assign unused_rd = ^{arready, rvalid, rresp, rdata, arvalid_q};
  assign arvalid   = 1'b0;
  assign rready    = 1'b0;
`endif

endmodule

// File: tb/tb_vfp_config_sequencer.sv
// Directed bench for vfp_config_sequencer: reactive AXI-Lite slave on the falling edge,
// hand-computed expectations for ordering, latency, eof sync, error and timeout paths.
module tb_vfp_config_sequencer;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TAW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          tbl_we;
  logic [TAW-1:0] tbl_idx;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_data;
  logic [TAW:0]  num_entries;
  logic          sync_frame, eof, start;
  logic          busy, done, error;
  logic [TAW-1:0] err_idx;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  always #5 clk = ~clk;

  vfp_config_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TBL_DEPTH(16), .TBL_AW(TAW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .num_entries(num_entries), .sync_frame(sync_frame), .eof(eof), .start(start),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // slave configuration (set before reset)
  int          aw_delay = 0;
  int          w_delay  = 0;
  bit          b_never  = 1'b0;
  int          bad_wr_idx = -1;
  bit          rd_corrupt = 1'b0;
  logic [31:0] rd_corrupt_val = '0;

  // slave state and monitor counters, owned by the negedge process
  int          aw_cnt, w_cnt, wr_num;
  bit          aw_pend, w_pend, aw_got, w_got, b_pend, ar_pend, r_pend;
  logic [7:0]  ar_addr;
  logic [31:0] mem [256];
  logic [7:0]  log_addr [$];
  logic [31:0] log_data [$];
  int          busy_cnt, done_cnt, awv_cnt, wv_cnt, bready_cnt, rd_cnt, aw_unstable;
  bit          prev_awv;
  logic [7:0]  prev_awaddr;

  always @(negedge clk) begin
    if (reset) begin
      awready = (aw_delay == 0); wready = (w_delay == 0);
      bvalid = 1'b0; bresp = 2'b00; arready = 1'b1; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
      aw_cnt = 0; w_cnt = 0; wr_num = 0;
      aw_pend = 0; w_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
      log_addr.delete(); log_data.delete();
      busy_cnt = 0; done_cnt = 0; awv_cnt = 0; wv_cnt = 0; bready_cnt = 0; rd_cnt = 0;
      aw_unstable = 0; prev_awv = 0; prev_awaddr = '0;
    end else begin
      if (prev_awv && awvalid && !aw_pend && (awaddr != prev_awaddr)) aw_unstable++;
      if (aw_pend) begin aw_pend = 0; aw_got = 1; aw_cnt = 0; if (aw_delay != 0) awready = 0; end
      if (w_pend)  begin w_pend = 0;  w_got = 1;  w_cnt = 0;  if (w_delay != 0)  wready = 0;  end
      if (b_pend) begin
        b_pend = 0; bvalid = 1'b0;
        $display("wr addr=0x%02h data=0x%08h bresp=%0d", log_addr[$], log_data[$], bresp);
        wr_num++;
      end
      if (aw_got && w_got && !bvalid && !b_never) begin
        aw_got = 0; w_got = 0; bvalid = 1'b1;
        bresp = (wr_num == bad_wr_idx) ? 2'b10 : 2'b00;
        mem[log_addr[$]] = log_data[$];
      end
      if (!awready && awvalid) begin if (aw_cnt == aw_delay) awready = 1; else aw_cnt++; end
      if (!wready && wvalid)   begin if (w_cnt == w_delay)   wready = 1;  else w_cnt++;  end
      if (awvalid && awready) begin aw_pend = 1; log_addr.push_back(awaddr); end
      if (wvalid && wready)   begin w_pend = 1;  log_data.push_back(wdata);  end
      if (bvalid && bready) b_pend = 1;
      if (r_pend) begin r_pend = 0; rvalid = 1'b0; end
      if (ar_pend) begin
        ar_pend = 0; rvalid = 1'b1; rresp = 2'b00;
        rdata = rd_corrupt ? rd_corrupt_val : mem[ar_addr];
      end
      if (arvalid && arready) begin ar_pend = 1; ar_addr = araddr; end
      if (rvalid && rready) r_pend = 1;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (awvalid) awv_cnt++;
      if (wvalid) wv_cnt++;
      if (bready) bready_cnt++;
      if (arvalid || rready) rd_cnt++;
      prev_awv = awvalid; prev_awaddr = awaddr;
    end
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input int i, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    tbl_we = 1'b1; tbl_idx = TAW'(i); tbl_addr = a; tbl_data = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic run_seq(input int n, input bit sync);
    @(negedge clk);
    num_entries = (TAW+1)'(n); sync_frame = sync; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int k = 0;
    while (done_cnt <= base && k < 2000) begin @(negedge clk); k++; end
    check({tag, "_done_seen"}, 32'(done_cnt > base), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  logic [7:0]  exp_a [3] = '{8'h00, 8'h04, 8'h08};
  logic [31:0] exp_d [3] = '{32'h1, 32'hA5A5, 32'hFF};

`ifdef VFP_CFG_READBACK_EN
  localparam int RB_EXTRA = 2;
`else
  localparam int RB_EXTRA = 0;
`endif

  initial begin
    reset = 1'b1; tbl_we = 0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
    num_entries = '0; sync_frame = 0; eof = 0; start = 0;
    do_reset();

    // reset state
    check("rst_busy", busy, 0);       check("rst_done", done, 0);
    check("rst_error", error, 0);     check("rst_err_idx", err_idx, 0);
    check("rst_awvalid", awvalid, 0); check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);   check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);   check("rst_wstrb", wstrb, 32'hF);
    check("rst_awprot", awprot, 0);   check("rst_arprot", arprot, 0);

    // T1: zero-wait slave, three entries in order, 4 cycles each
    for (int i = 0; i < 3; i++) load(i, exp_a[i], exp_d[i]);
    run_seq(3, 0);
    wait_done("t1", 0);
    check("t1_nwrites", log_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("t1_addr", (i < log_addr.size()) ? 32'(log_addr[i]) : 32'hDEAD, 32'(exp_a[i]));
      check("t1_data", (i < log_data.size()) ? log_data[i] : 32'hDEAD, exp_d[i]);
    end
    check("t1_busy_cycles", busy_cnt, 3 * (4 + RB_EXTRA));
    check("t1_done_pulses", done_cnt, 1);
    check("t1_error", error, 0);
`ifndef VFP_CFG_READBACK_EN
    check("t1_no_read_traffic", rd_cnt, 0);
`endif

    // T2: awready delayed 3 cycles, wready immediate
    aw_delay = 3; do_reset();
    run_seq(3, 0);
    wait_done("t2", 0);
    check("t2_awvalid_cycles", awv_cnt, 12);
    check("t2_wvalid_cycles", wv_cnt, 3);
    check("t2_nwrites", log_addr.size(), 3);
    check("t2_awaddr_stable", aw_unstable, 0);
    check("t2_busy_cycles", busy_cnt, 3 * (7 + RB_EXTRA));
    check("t2_error", error, 0);
    aw_delay = 0;

    // T3: frame sync; eof coincident with start is ignored, as is a start while busy
    do_reset();
    @(negedge clk);
    num_entries = 5'd3; sync_frame = 1; start = 1; eof = 1;
    @(negedge clk);
    start = 0; eof = 0;
    repeat (20) @(negedge clk);
    num_entries = 5'd0; start = 1;
    @(negedge clk);
    start = 0; num_entries = 5'd3;
    repeat (28) @(negedge clk);
    check("t3_busy_waiting", busy, 1);
    check("t3_no_aw_before_eof", awv_cnt, 0);
    check("t3_no_done_before_eof", done_cnt, 0);
    eof = 1;
    check("t3_awvalid_at_eof", awvalid, 0);
    @(negedge clk);
    eof = 0;
    check("t3_awvalid_after_eof", awvalid, 1);
    wait_done("t3", 0);
    check("t3_nwrites", log_addr.size(), 3);
    check("t3_done_pulses", done_cnt, 1);

    // T4: SLVERR on entry 1 of 3
    bad_wr_idx = 1; do_reset();
    run_seq(3, 0);
    wait_done("t4", 0);
    check("t4_error", error, 1);
    check("t4_err_idx", err_idx, 1);
    check("t4_nwrites", log_addr.size(), 2);
    check("t4_done_pulses", done_cnt, 1);

    // T4b: next start clears the sticky error
    bad_wr_idx = -1;
    run_seq(3, 0);
    wait_done("t4b", 1);
    check("t4b_error_cleared", error, 0);
    check("t4b_nwrites", log_addr.size(), 5);

    // T5: bvalid never arrives -> timeout after 16 cycles in WR_RESP
    b_never = 1; do_reset();
    run_seq(1, 0);
    wait_done("t5", 0);
    check("t5_bready_cycles", bready_cnt, 16);
    check("t5_error", error, 1);
    check("t5_err_idx", err_idx, 0);
    check("t5_bready_dropped", bready, 0);
    check("t5_done_pulses", done_cnt, 1);
    b_never = 0;

    // T6: zero entries -> done only, no traffic
    do_reset();
    run_seq(0, 0);
    wait_done("t6", 0);
    check("t6_nwrites", log_addr.size(), 0);
    check("t6_busy_cycles", busy_cnt, 0);
    check("t6_done_pulses", done_cnt, 1);

`ifdef VFP_CFG_READBACK_EN
    // T7: readback mismatch on entry 0
    rd_corrupt = 1; rd_corrupt_val = 32'h1234; do_reset();
    load(0, 8'h10, 32'h1235);
    run_seq(1, 0);
    wait_done("t7", 0);
    check("t7_error", error, 1);
    check("t7_err_idx", err_idx, 0);
    rd_corrupt = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
